// File: rtl/rr_bus_arbiter.sv
// N-way round-robin bus arbiter with registered one-hot grant and per-master bus lock.
// Define BUS_ARB_HOLD_LIMIT_EN to bound how long a lock can hold the bus while others wait.
module rr_bus_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = $clog2(N),
    parameter int HOLD_MAX = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           hold_timeout
);

    if (N < 2 || N > 16 || HOLD_MAX < 1) begin : g_bad_params
        $error("rr_bus_arbiter: illegal parameter value");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [N-1:0]   grant_n;
    logic [IDW-1:0] grant_id_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [IDW-1:0] win_id;
    logic           win_found;
    logic           keep_raw;
    logic           keep;

    always_comb begin
        keep_raw = (state == OWNED) && req[grant_id] && lock[grant_id];
    end

    // First requester found scanning upward from ptr, wrapping mod N.
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

`ifdef BUS_ARB_HOLD_LIMIT_EN
    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    logic [CW-1:0] hold_cnt;
    logic          force_break;

    // A lock expires only when someone else is waiting; otherwise the counter saturates.
    always_comb begin
        force_break = keep_raw && (hold_cnt == CNT_LAST) && (|(req & ~grant));
        keep        = keep_raw && !force_break;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt     <= '0;
            hold_timeout <= 1'b0;
        end else begin
            hold_timeout <= force_break;
            if (keep) begin
                if (hold_cnt != CNT_LAST)
                    hold_cnt <= hold_cnt + CW'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    always_comb begin
        keep         = keep_raw;
        hold_timeout = 1'b0;
    end
`endif

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        grant_id_n = grant_id;
        ptr_n      = ptr;
        if (keep) begin
            state_n = OWNED;
        end else if (win_found) begin
            state_n          = OWNED;
            grant_n          = '0;
            grant_n[win_id]  = 1'b1;
            grant_id_n       = win_id;
            ptr_n            = (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
        end else begin
            state_n    = IDLE;
            grant_n    = '0;
            grant_id_n = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            grant_id <= grant_id_n;
            ptr      <= ptr_n;
        end
    end

    always_comb begin
        grant_valid = (state == OWNED);
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench for rr_bus_arbiter: directed scenarios plus sticky random req/lock traffic.
// Reference model tracks owner/pointer as integers; build with BUS_ARB_HOLD_LIMIT_EN to cover the hold limit.
module tb_rr_bus_arbiter;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int HOLD_MAX = 4;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   lock  = '0;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;
    logic           hold_timeout;

    rr_bus_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .lock(lock),
        .grant(grant),
        .grant_id(grant_id),
        .grant_valid(grant_valid),
        .hold_timeout(hold_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   g;
        logic [IDW-1:0] id;
        logic           v;
        logic           to;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: owner index (-1 = idle), priority pointer, lock-hold count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
        bit   keep;
        bit   to;
        int   w;
        exp_t e;
        keep = 0;
        to   = 0;
        if (m_owner >= 0) keep = r[m_owner] && l[m_owner];
`ifdef BUS_ARB_HOLD_LIMIT_EN
        if (keep && m_cnt == HOLD_MAX - 1) begin
            logic [N-1:0] others;
            others = r;
            others[m_owner] = 1'b0;
            if (others != 0) begin
                keep = 0;
                to   = 1;
            end
        end
`endif
        if (keep) begin
            if (m_cnt < HOLD_MAX - 1) m_cnt++;
        end else if (r != 0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            m_owner = w;
            m_ptr   = (w + 1) % N;
            m_cnt   = 0;
        end else begin
            m_owner = -1;
            m_cnt   = 0;
        end
        e.g  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e.id = (m_owner >= 0) ? IDW'(m_owner) : '0;
        e.v  = (m_owner >= 0);
        e.to = to;
        exp_q.push_back(e);
    endtask

    // One cycle: drive on the falling edge, return shortly after the following rising edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l);
        @(negedge clk);
        req  = r;
        lock = l;
        model_step(r, l);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        @(negedge clk);
        reset = 1'b1;
        req   = r;
        lock  = '0;
        exp_q.delete();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        check("rst_timeout", 32'(hold_timeout), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_step(r, '0);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant", 32'(grant), 32'(e.g));
                check("grant_id", 32'(grant_id), 32'(e.id));
                check("grant_valid", 32'(grant_valid), 32'(e.v));
                check("hold_timeout", 32'(hold_timeout), 32'(e.to));
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] seq2 [4];
        logic [N-1:0] r_s;
        logic [N-1:0] l_s;
        seq2[0] = 4'b0010; seq2[1] = 4'b0100; seq2[2] = 4'b1000; seq2[3] = 4'b0001;

        // Reset with all requests pending, then first grant to master 0.
        do_reset(4'b1111);
        check("t1_first", 32'(grant), 32'h1);

        // Full rotation with everyone requesting.
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 4'b0000);
            check("t2_rotate", 32'(grant), 32'(seq2[i]));
        end

        // Two requesters alternate.
        for (int i = 0; i < 3; i++) begin
            step(4'b1010, 4'b0000);
            check("t3_id", 32'(grant_id), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Lock on master 2 once it owns the bus.
        do_reset(4'b1111);
        step(4'b1111, 4'b0000);
        step(4'b1111, 4'b0000);
        check("t4_own2", 32'(grant), 32'h4);
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 4'b0100);
`ifndef BUS_ARB_HOLD_LIMIT_EN
            check("t4_hold", 32'(grant), 32'h4);
`endif
        end
        step(4'b1111, 4'b0000);
`ifndef BUS_ARB_HOLD_LIMIT_EN
        check("t4_release", 32'(grant), 32'h8);
`endif

        // Reset while master 3 owns the bus.
        do_reset(4'b1111);
        step(4'b1111, 4'b0000);
        step(4'b1111, 4'b0000);
        step(4'b1111, 4'b0000);
        check("t5_own3", 32'(grant), 32'h8);
        do_reset(4'b1111);
        check("t5_after", 32'(grant), 32'h1);

`ifdef BUS_ARB_HOLD_LIMIT_EN
        // Lock broken after HOLD_MAX cycles when another master waits.
        do_reset(4'b0100);
        check("t6_own2", 32'(grant), 32'h4);
        for (int i = 0; i < 3; i++) begin
            step(4'b0101, 4'b0100);
            check("t6_held", 32'(grant), 32'h4);
            check("t6_no_pulse", 32'(hold_timeout), 32'h0);
        end
        step(4'b0101, 4'b0100);
        check("t6_broken", 32'(grant), 32'h1);
        check("t6_pulse", 32'(hold_timeout), 32'h1);
        step(4'b0101, 4'b0000);
        check("t6_pulse_end", 32'(hold_timeout), 32'h0);

        // Sole requester keeps the bus indefinitely.
        do_reset(4'b0100);
        for (int i = 0; i < 8; i++) begin
            step(4'b0100, 4'b0100);
            check("t6b_held", 32'(grant), 32'h4);
            check("t6b_no_pulse", 32'(hold_timeout), 32'h0);
        end
`endif

        // Random traffic: sticky request and lock bits, occasional reset.
        do_reset('0);
        r_s = '0;
        l_s = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 4) == 0) r_s[b] = ~r_s[b];
                if ($urandom_range(0, 7) == 0) l_s[b] = ~l_s[b];
            end
            if ($urandom_range(0, 299) == 0)
                do_reset(r_s);
            else
                step(r_s, l_s);
        end

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
